snow_render: RTL and testbench

//  Pixel-stage renderer that sits directly downstream of the 640x480 display timing generator.

---
 rtl/snow_render_if.sv | 33 +++
 rtl/snow_render.sv | 137 +++++++++++++
 tb/tb_snow_render.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/snow_render_if.sv
// Purpose: pixel-stream bundle between the display timing generator and snow_render.
// Latency: none; this is wiring only.
// Backpressure: none; the pixel stream free-runs on the pixel clock.
// Ports:
//   timing side -> renderer : sx, sy, de_in, hsync_in, vsync_in, pause
//   renderer -> display     : r, g, b, de_out, hsync_out, vsync_out, busy
interface snow_render_if;
  logic [9:0] sx;
  logic [9:0] sy;
  logic       de_in;
  logic       hsync_in;
  logic       vsync_in;
  logic       pause;
  logic [3:0] r;
  logic [3:0] g;
  logic [3:0] b;
  logic       de_out;
  logic       hsync_out;
  logic       vsync_out;
  logic       busy;

  // master: whoever generates timing and consumes pixels (timing generator / bench)
  modport master (
    output sx, sy, de_in, hsync_in, vsync_in, pause,
    input  r, g, b, de_out, hsync_out, vsync_out, busy
  );

  // slave: the renderer itself
  modport slave (
    input  sx, sy, de_in, hsync_in, vsync_in, pause,
    output r, g, b, de_out, hsync_out, vsync_out, busy
  );
endinterface

// File: rtl/snow_render.sv
// Purpose: draws FLAKES white square snowflakes over a dark-blue background,
//          moving them once per frame during vertical blanking.
// Latency: fixed 2 pixel clocks from sx/sy/de/syncs to rgb/de_out/syncs.
// Backpressure: none; the pixel stream cannot be stalled.
// Ports:
//   clk_pix  pixel clock
//   rst_pix  synchronous active-high reset
//   px       snow_render_if.slave: timing inputs, pause, rgb/sync outputs, busy
module snow_render #(
  parameter int          FLAKES     = 8,
  parameter int          FLAKE_SIZE = 4,
  parameter int          H_RES      = 640,
  parameter int          V_RES      = 480,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input logic          clk_pix,
  input logic          rst_pix,
  snow_render_if.slave px
);

  localparam int          IW     = (FLAKES > 1) ? $clog2(FLAKES) : 1;
  localparam int          H_STEP = H_RES / FLAKES;
  localparam int          V_STEP = V_RES / FLAKES;
  localparam logic [IW-1:0] LAST = IW'(FLAKES - 1);

  typedef enum logic {IDLE, UPDATE} state_t;

  state_t        state;
  state_t        state_nx;
  logic [IW-1:0] idx;
  logic [15:0]   lfsr;
  logic [15:0]   lfsr_step;

  logic [9:0] fx [FLAKES];
  logic [9:0] fy [FLAKES];
  logic [1:0] fs [FLAKES];

  // ---------------- pixel pipe ----------------
  logic hit;
  logic s1_de, s1_hs, s1_vs, s1_hit;

  // Compares are widened to 11 bits so x+FLAKE_SIZE never wraps near 1023.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < FLAKES; i++) begin
      if ({1'b0, px.sx} >= {1'b0, fx[i]} &&
          {1'b0, px.sx} <  {1'b0, fx[i]} + 11'(FLAKE_SIZE) &&
          {1'b0, px.sy} >= {1'b0, fy[i]} &&
          {1'b0, px.sy} <  {1'b0, fy[i]} + 11'(FLAKE_SIZE))
        hit = 1'b1;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      s1_de        <= 1'b0;
      s1_hs        <= 1'b1;
      s1_vs        <= 1'b1;
      s1_hit       <= 1'b0;
      px.de_out    <= 1'b0;
      px.hsync_out <= 1'b1;
      px.vsync_out <= 1'b1;
      px.r         <= 4'h0;
      px.g         <= 4'h0;
      px.b         <= 4'h0;
    end else begin
      s1_de        <= px.de_in;
      s1_hs        <= px.hsync_in;
      s1_vs        <= px.vsync_in;
      s1_hit       <= hit;
      px.de_out    <= s1_de;
      px.hsync_out <= s1_hs;
      px.vsync_out <= s1_vs;
      if (!s1_de) begin
        px.r <= 4'h0; px.g <= 4'h0; px.b <= 4'h0;
      end else if (s1_hit) begin
        px.r <= 4'hF; px.g <= 4'hF; px.b <= 4'hF;
      end else begin
        px.r <= 4'h0; px.g <= 4'h1; px.b <= 4'h4;
      end
    end
  end

  // ---------------- update FSM ----------------
  logic       trigger;
  logic [10:0] ny;
  logic [9:0]  c;
  logic [9:0]  cx;

  // First blanking line start; pause only matters at this instant.
  assign trigger = (px.sx == 10'd0) && (px.sy == 10'(V_RES)) && !px.pause;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (trigger) state_nx = UPDATE;
      UPDATE:  if (idx == LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign px.busy   = (state == UPDATE);
  assign lfsr_step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  // Respawn column: fold values past the right edge back by 512 so the
  // whole flake stays on screen.
  assign ny = {1'b0, fy[idx]} + 11'(fs[idx]) + 11'd1;
  assign c  = lfsr[9:0];
  assign cx = (c > 10'(H_RES - FLAKE_SIZE)) ? c - 10'd512 : c;

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state <= IDLE;
      idx   <= '0;
      lfsr  <= LFSR_SEED;
      for (int i = 0; i < FLAKES; i++) begin
        fx[i] <= 10'(i * H_STEP);
        fy[i] <= 10'(i * V_STEP);
        fs[i] <= 2'(i);
      end
    end else begin
      state <= state_nx;
      if (state == UPDATE) begin
        lfsr <= lfsr_step;
        idx  <= (idx == LAST) ? '0 : IW'(idx + 1'b1);
        if (ny >= 11'(V_RES)) begin
          fy[idx] <= 10'd0;
          fs[idx] <= lfsr[11:10];
          fx[idx] <= cx;
        end else begin
          fy[idx] <= ny[9:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_snow_render.sv
module tb_snow_render;

  logic clk_pix = 1'b0;
  logic rst_pix = 1'b1;
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk_pix = ~clk_pix;
  always @(posedge clk_pix) cyc <= cyc + 1;

  snow_render_if bus ();

  snow_render dut (
    .clk_pix (clk_pix),
    .rst_pix (rst_pix),
    .px      (bus)
  );

  typedef struct {
    int          due;
    logic [14:0] exp;      // {r,g,b,de,hs,vs}
    bit          rgb_chk;
    string       name;
  } sb_t;
  sb_t q[$];

  localparam logic [11:0] WHITE = 12'hFFF;
  localparam logic [11:0] BLUE  = 12'h014;
  localparam logic [11:0] BLACK = 12'h000;

  // reference flake state
  int          mx [8];
  int          my [8];
  int          ms [8];
  logic [15:0] mlfsr;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mx[i] = i * 80; my[i] = i * 60; ms[i] = i % 4;
    end
    mlfsr = 16'hACE1;
  endtask

  task automatic model_update();
    for (int i = 0; i < 8; i++) begin
      int ny;
      ny = my[i] + ms[i] + 1;
      if (ny >= 480) begin
        int cc;
        cc    = int'(mlfsr[9:0]);
        my[i] = 0;
        ms[i] = int'(mlfsr[11:10]);
        mx[i] = (cc > 636) ? cc - 512 : cc;
      end else begin
        my[i] = ny;
      end
      mlfsr = mlfsr[0] ? ((mlfsr >> 1) ^ 16'hB400) : (mlfsr >> 1);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic set_idle();
    bus.sx = 10'd700; bus.sy = 10'd500;
    bus.de_in = 1'b0; bus.hsync_in = 1'b1; bus.vsync_in = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_pix);
      set_idle();
    end
  endtask

  task automatic drv(input int sx, input int sy, input bit de, input bit hs, input bit vs,
                     input bit rgb_chk, input logic [11:0] rgb, input string name);
    sb_t e;
    @(negedge clk_pix);
    bus.sx = 10'(sx); bus.sy = 10'(sy);
    bus.de_in = de; bus.hsync_in = hs; bus.vsync_in = vs;
    e.due = cyc + 2; e.exp = {rgb, de, hs, vs}; e.rgb_chk = rgb_chk; e.name = name;
    q.push_back(e);
  endtask

  // Trigger one update and count busy cycles; pause is raised pause_at cycles in (-1 = never).
  task automatic trig_count(output int n, input int pause_at);
    n = 0;
    @(negedge clk_pix);
    bus.sx = 10'd0; bus.sy = 10'd480; bus.de_in = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk_pix);
      set_idle();
      if (bus.busy) n++;
      if (j == pause_at) bus.pause = 1'b1;
    end
  endtask

  task automatic cmp_flakes(input string tag);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_x%0d", tag, i), int'(dut.fx[i]), mx[i]);
      chk($sformatf("%s_y%0d", tag, i), int'(dut.fy[i]), my[i]);
      chk($sformatf("%s_s%0d", tag, i), int'(dut.fs[i]), ms[i]);
    end
  endtask

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge clk_pix);
      while (q.size() > 0 && q[0].due <= cyc) begin
        sb_t e;
        logic [14:0] act;
        e   = q.pop_front();
        act = {bus.r, bus.g, bus.b, bus.de_out, bus.hsync_out, bus.vsync_out};
        if (!e.rgb_chk) begin
          act[14:3]   = 12'h0;
          e.exp[14:3] = 12'h0;
        end
        nvec++;
        if (e.due < cyc) begin
          nerr++;
          $display("FAIL %s: output missed at cycle %0d, due %0d", e.name, cyc, e.due);
        end else if (act != e.exp) begin
          nerr++;
          $display("FAIL %s: rgb/de/hs/vs got %h want %h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    int n;
    int waited;
    bit de, hs, vs;

    bus.pause = 1'b0;
    set_idle();
    model_reset();

    // reset state
    repeat (5) @(posedge clk_pix);
    @(negedge clk_pix);
    chk("rst_rgb", int'({bus.r, bus.g, bus.b}), 0);
    chk("rst_de", int'(bus.de_out), 0);
    chk("rst_hs", int'(bus.hsync_out), 1);
    chk("rst_vs", int'(bus.vsync_out), 1);
    chk("rst_busy", int'(bus.busy), 0);
    rst_pix = 1'b0;

    // sync/de delay in a flake-free region
    for (int k = 0; k < 30; k++) begin
      de = 1'($urandom_range(0, 1));
      hs = 1'($urandom_range(0, 1));
      vs = 1'($urandom_range(0, 1));
      drv(600 + int'($urandom_range(0, 39)), 470, de, hs, vs, 1'b1,
          de ? BLUE : BLACK, "delay");
    end

    // initial flake positions
    drv(0,  0,  1, 1, 1, 1'b1, WHITE, "p0_0");
    drv(4,  0,  1, 1, 1, 1'b1, BLUE,  "p4_0");
    drv(80, 60, 1, 1, 1, 1'b1, WHITE, "p80_60");
    drv(3,  3,  1, 1, 1, 1'b1, WHITE, "p3_3");
    drv(0,  4,  1, 1, 1, 1'b1, BLUE,  "p0_4");
    drv(0,  0,  0, 0, 1, 1'b1, BLACK, "p0_0_blank");
    idle(4);

    // first update
    trig_count(n, -1);
    chk("busy_len", n, 8);
    model_update();
    chk("f3_y", int'(dut.fy[3]), 184);
    drv(0, 0, 1, 1, 1, 1'b1, BLUE,  "u1_p0_0");
    drv(0, 1, 1, 1, 1, 1'b1, WHITE, "u1_p0_1");
    drv(3, 4, 1, 1, 1, 1'b1, WHITE, "u1_p3_4");
    drv(0, 5, 1, 1, 1, 1'b1, BLUE,  "u1_p0_5");
    idle(4);

    // frames 2..15: flake 7 respawns on the 15th
    for (int f = 2; f <= 15; f++) begin
      trig_count(n, -1);
      model_update();
    end
    chk("f7_y", int'(dut.fy[7]), 0);
    chk("f7_x", int'(dut.fx[7]), mx[7]);
    chk("f7_s", int'(dut.fs[7]), ms[7]);
    chk("f7_x_range", int'(dut.fx[7] <= 10'd636), 1);
    cmp_flakes("f15");
    drv(mx[7], 0, 1, 1, 1, 1'b1, WHITE, "f7_pix");
    idle(4);

    // pause at trigger: no update
    bus.pause = 1'b1;
    trig_count(n, -1);
    chk("pause_busy", n, 0);
    cmp_flakes("pause");
    bus.pause = 1'b0;

    // pause raised mid-update: update completes
    trig_count(n, 2);
    chk("pause_mid_busy", n, 8);
    model_update();
    cmp_flakes("pmid");
    bus.pause = 1'b0;

    // reset during update at idx 3
    @(negedge clk_pix);
    bus.sx = 10'd0; bus.sy = 10'd480;
    waited = 0;
    do begin
      @(negedge clk_pix);
      set_idle();
      waited++;
    end while (!(bus.busy && dut.idx == 3) && waited < 20);
    chk("reach_idx3", int'(waited < 20), 1);
    rst_pix = 1'b1;
    @(negedge clk_pix);
    rst_pix = 1'b0;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_lfsr", int'(dut.lfsr), 16'hACE1);
    model_reset();
    cmp_flakes("midrst");
    idle(1);
    drv(0, 0, 1, 1, 1, 1'b1, WHITE, "midrst_p0_0");
    idle(4);

    if (q.size() != 0) begin
      nvec++;
      nerr++;
      $display("FAIL sb_drain: %0d entries left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
